// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side control bundle between the PC sequencer and its users.
// The master drives the control inputs and the slave (pc_sequencer) drives the PC outputs.
// Optional macro PC_SEQ_ALIGN_TRAP_EN adds the misalign output.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);

  // Control inputs to the sequencer
  logic              stall;
  logic              halt_req;
  logic [31:0]       instruction;
  logic              zero;
  logic              branch_sel;
  logic              jump_sel;
  logic              link_sel;
  logic              jr_sel;
  logic [ADDR_W-1:0] jr_target;

  // Sequencer outputs
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              redirect;
`ifdef PC_SEQ_ALIGN_TRAP_EN
  logic              misalign;
`endif

  modport master (
    output stall, halt_req, instruction, zero, branch_sel, jump_sel, link_sel, jr_sel,
           jr_target,
    input  pc, pc_valid, link_addr, ras_top, ras_empty, redirect
`ifdef PC_SEQ_ALIGN_TRAP_EN
    , input misalign
`endif
  );

  modport slave (
    input  stall, halt_req, instruction, zero, branch_sel, jump_sel, link_sel, jr_sel,
           jr_target,
    output pc, pc_valid, link_addr, ras_top, ras_empty, redirect
`ifdef PC_SEQ_ALIGN_TRAP_EN
    , output misalign
`endif
  );

endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit with boot/run/halt FSM, stall, and a circular
// return-address stack (RAS) that predicts jr $ra targets.
// Optional macro PC_SEQ_ALIGN_TRAP_EN: a misaligned jr target traps to RESET_VEC + 0x80 and
// pulses the misalign output; without it the jr target has its low two bits cleared.
// Parameter limits: ADDR_W >= 28; RAS_DEPTH a power of two, >= 2.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  localparam int unsigned       PtrW    = $clog2(RAS_DEPTH);
  localparam int unsigned       CntW    = PtrW + 1;
  localparam logic [CntW-1:0]   CntMax  = CntW'(RAS_DEPTH);
  // Low 28 bits come from the j/jal immediate; the rest from pc+4
  localparam logic [ADDR_W-1:0] JLoMask = ADDR_W'(28'hFFF_FFFF);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pc_valid;
  logic              r_redirect;
  logic [PtrW-1:0]   r_top;
  logic [CntW-1:0]   r_count;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic [ADDR_W-1:0] w_p4;
  logic [ADDR_W-1:0] w_boff;
  logic [ADDR_W-1:0] w_btarget;
  logic [ADDR_W-1:0] w_jtarget;
  logic [ADDR_W-1:0] w_jr_dest;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_non_seq;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_ras_we;
  logic [PtrW-1:0]   w_ras_wptr;
  logic              w_unused;

  assign w_p4      = r_pc + ADDR_W'(4);
  assign w_boff    = {{(ADDR_W-18){bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
  assign w_btarget = w_p4 + w_boff;
  assign w_jtarget = (w_p4 & ~JLoMask) | ADDR_W'({bus.instruction[25:0], 2'b00});

`ifdef PC_SEQ_ALIGN_TRAP_EN
  localparam logic [ADDR_W-1:0] TrapVec = RESET_VEC + ADDR_W'(32'h80);

  logic w_misalign;
  logic r_misalign;

  assign w_misalign   = bus.jr_sel && (bus.jr_target[1:0] != 2'b00);
  assign w_jr_dest    = w_misalign ? TrapVec : bus.jr_target;
  assign bus.misalign = r_misalign;
  assign w_unused     = ^bus.instruction[31:26];
`else
  assign w_jr_dest    = {bus.jr_target[ADDR_W-1:2], 2'b00};
  assign w_unused     = ^{bus.instruction[31:26], bus.jr_target[1:0]};
`endif

  // A cycle is accepted only in RUN, unstalled and not entering HALT
  assign w_accept = (r_state == StRun) && !bus.stall && !bus.halt_req;
  assign w_push   = bus.link_sel && bus.jump_sel;
  assign w_pop    = bus.jr_sel;

  // Next-PC source selection: jr > jump > taken branch > sequential
  always_comb begin
    w_next_pc = w_p4;
    w_non_seq = 1'b0;
    if (bus.jr_sel) begin
      w_next_pc = w_jr_dest;
      w_non_seq = 1'b1;
    end else if (bus.jump_sel) begin
      w_next_pc = w_jtarget;
      w_non_seq = 1'b1;
    end else if (bus.branch_sel && bus.zero) begin
      w_next_pc = w_btarget;
      w_non_seq = 1'b1;
    end
  end

  // RAS write port: push goes above top, push+pop overwrites the current top
  assign w_ras_we   = w_accept && w_push;
  assign w_ras_wptr = w_pop ? r_top : r_top + PtrW'(1);

  // RAS storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_ras_we) begin
      r_ras[w_ras_wptr] <= w_p4;
    end
  end

  // FSM with registered PC, valid, redirect and RAS pointer/count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StBoot;
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
      r_redirect <= 1'b0;
      r_top      <= '0;
      r_count    <= '0;
`ifdef PC_SEQ_ALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StBoot: begin
          r_state    <= StRun;
          r_pc_valid <= 1'b1;
        end
        StRun: begin
          if (!bus.stall) begin
            if (bus.halt_req) begin
              r_state    <= StHalt;
              r_pc_valid <= 1'b0;
              r_redirect <= 1'b0;
`ifdef PC_SEQ_ALIGN_TRAP_EN
              r_misalign <= 1'b0;
`endif
            end else begin
              r_pc       <= w_next_pc;
              r_redirect <= w_non_seq;
`ifdef PC_SEQ_ALIGN_TRAP_EN
              r_misalign <= w_misalign;
`endif
              if (w_push && w_pop) begin
                // Top entry replaced in place; pointer and count unchanged
                r_top <= r_top;
              end else if (w_push) begin
                r_top <= r_top + PtrW'(1);
                if (r_count != CntMax) begin
                  r_count <= r_count + CntW'(1);
                end
              end else if (w_pop && (r_count != '0)) begin
                r_top   <= r_top - PtrW'(1);
                r_count <= r_count - CntW'(1);
              end
            end
          end
        end
        StHalt: begin
          // Frozen until reset
          r_state <= StHalt;
        end
        default: begin
          r_state <= StBoot;
        end
      endcase
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pc_valid  = r_pc_valid;
  assign bus.redirect  = r_redirect;
  assign bus.link_addr = w_p4;
  assign bus.ras_empty = (r_count == '0);
  assign bus.ras_top   = (r_count != '0) ? r_ras[r_top] : '0;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the MIPS-style core. It holds the PC register and selects the next PC from sequential, conditional-branch, absolute-jump and jump-register sources. It adds stall, halt and a return-address stack (RAS) that predicts `jr $ra` targets. It sits between instruction memory and the decode/control logic, replacing the purely combinational next-PC path.

Parameters:
- ADDR_W, 32: PC width. Must be ≥ 28.
- RESET_VEC, 0: PC value loaded at reset.
- RAS_DEPTH, 4: number of RAS entries. Must be a power of two and ≥ 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  freeze PC, FSM and RAS this cycle
- halt_req  in  1  enter HALT
- instruction  in  32  current fetched instruction
- zero  in  1  ALU zero flag
- branch_sel  in  1  conditional branch
- jump_sel  in  1  absolute jump (j/jal)
- link_sel  in  1  jal: push return address
- jr_sel  in  1  jump register
- jr_target  in  ADDR_W  register-file value for jr
- pc  out  ADDR_W  current PC
- pc_valid  out  1  PC is a valid fetch address
- link_addr  out  ADDR_W  pc+4, for writeback of $ra
- ras_top  out  ADDR_W  predicted return address; 0 when empty
- ras_empty  out  1  RAS holds no entries
- redirect  out  1  next PC is not pc+4 (registered, for flush)

Behaviour:
- Reset (async on rst_n low):
  - pc = RESET_VEC, pc_valid = 0, redirect = 0, ras_empty = 1, ras_top = 0.
  - RAS count = 0. FSM = BOOT.
- FSM:
  - BOOT: next cycle goes to RUN, pc_valid = 1. The PC is not advanced in BOOT.
  - RUN: normal operation. halt_req (not stalled) goes to HALT.
  - HALT: pc frozen, pc_valid = 0. Exit only by reset. All control inputs are ignored.
- Next-PC (combinational, all arithmetic mod 2^ADDR_W):
  - p4 = pc + 4.
  - btarget = p4 + (sign_extend(instruction[15:0]) << 2).
  - jtarget = {p4[ADDR_W-1:28], instruction[25:0], 2'b00}.
- Priority: jr_sel → jr_target; else jump_sel → jtarget; else (branch_sel & zero) → btarget; else p4.
- The PC updates on the rising edge in RUN when stall = 0. In BOOT, HALT, or when stall = 1, pc holds.
- redirect is registered: it is set to 1 for one cycle when the PC loaded a non-p4 source; otherwise it is 0. It also holds during stall.
- link_addr = p4 (combinational).
- RAS: circular buffer with top pointer and count, saturating at RAS_DEPTH. It updates only on RUN cycles with stall = 0.
  - Push (link_sel & jump_sel): write p4 at top+1, top advances. When full, the oldest entry is overwritten and count stays RAS_DEPTH.
  - Pop (jr_sel): top retreats, count decrements. Pop when empty is a no-op.
  - Push and pop in the same cycle: the top entry is replaced with p4, count unchanged.
  - link_sel without jump_sel: no push.
- ras_top = entry at top when count > 0, else 0. ras_empty = (count == 0).
- Reset mid-operation: all state returns to reset values immediately. Stored RAS contents become don't-care but are never visible.

Optional Feature:
- Macro: PC_SEQ_ALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit, registered, reset 0).
  - If the selected jr_target has bits [1:0] ≠ 0 while jr_sel is accepted, pc loads RESET_VEC + 0x80 instead of jr_target, misalign pulses 1 for one cycle, and redirect = 1. The RAS still pops.
- Undefined:
  - No misalign port.
  - jr_target is loaded unchanged, with bits [1:0] forced to 00.

Test Plan:
1. Release reset with RESET_VEC=0x0 → BOOT for 1 cycle with pc_valid=0. Then pc steps 0x0, 0x4, 0x8 with pc_valid=1 and redirect=0.
2. pc=0x100, instruction imm16=0xFFFE, branch_sel=1, zero=1 → pc=0xFC, redirect=1 next cycle. Same with zero=0 → pc=0x104.
3. pc=0x10000010, jump_sel=1, instruction[25:0]=0x0000040 → pc=0x10000100.
4. RAS_DEPTH=4: five jal pushes from pc 0x0, 0x10, 0x20, 0x30, 0x40 → ras_top=0x44. Four jr pops yield ras_top 0x34, 0x24, 0x14, then 0 with ras_empty=1; the 0x4 entry is lost. A fifth pop changes nothing.
5. stall=1 with jump_sel=1 and link_sel=1 for 3 cycles → pc, RAS and redirect unchanged. On stall release the jump and push occur once.
6. halt_req=1 at pc=0x20 → pc stays 0x20 and pc_valid=0 despite jumps. Assert rst_n=0 mid-HALT → pc=RESET_VEC immediately.
